// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined ALU: FSM states, operation class and select codes.
package alu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic CLS_ARITH = 1'b1;
   localparam logic CLS_LOGIC = 1'b0;

   localparam logic [1:0] SEL_ADD = 2'b00;
   localparam logic [1:0] SEL_SUB = 2'b01;
   localparam logic [1:0] SEL_MUL = 2'b10;
   localparam logic [1:0] SEL_INC = 2'b11;

   localparam logic [1:0] SEL_AND = 2'b00;
   localparam logic [1:0] SEL_OR  = 2'b01;
   localparam logic [1:0] SEL_XOR = 2'b10;
   localparam logic [1:0] SEL_NOT = 2'b11;

   function automatic logic is_mul(input logic cls, input logic [1:0] sel);
      return (cls == CLS_ARITH) && (sel == SEL_MUL);
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one partial product per step, WIDTH steps per product.
// done_o is a combinational pulse in the last step; prod_o then carries the final product.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               step_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] prod_o,
   output logic               done_o
);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [CNT_W-1:0]   cnt_q;

   always_comb begin
      acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
      prod_o = acc_d;
      done_o = step_i && (cnt_q == CNT_W'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else if (start_i) begin
         acc_q    <= '0;
         mcand_q  <= {{WIDTH{1'b0}}, a_i};
         mplier_q <= b_i;
         cnt_q    <= '0;
      end else if (step_i) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with IDLE/BUSY/DONE control; single-cycle ops finish the cycle after acceptance.
// Define ALU_PIPE_MUL_EN to build the sequential multiplier; otherwise multiply reports illegal.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int MUL_CYCLES_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ctrl,
   input  logic [1:0]       S,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Y_hi,
   output logic             carry,
   output logic             zero,
   output logic             illegal,
   output logic             out_valid,
   input  logic             out_ready
);

   if (WIDTH < 4 || WIDTH > 32 || (2 ** MUL_CYCLES_W) < WIDTH) begin : g_cfg_check
      $error("alu_pipe: unsupported WIDTH/MUL_CYCLES_W combination");
   end

   state_e state_q, state_d;

   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] yhi_q, yhi_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             illegal_q, illegal_d;

   logic             accept;
   logic             req_mul;
   logic [WIDTH-1:0] alu_y;
   logic             alu_c;

   assign accept  = in_valid && (state_q == ST_IDLE);
   assign req_mul = is_mul(ctrl, S);

`ifdef ALU_PIPE_MUL_EN
   logic [2*WIDTH-1:0] mul_prod;
   logic               mul_done;

   alu_mul_seq #(
      .WIDTH (WIDTH),
      .CNT_W (MUL_CYCLES_W)
   ) u_mul (
      .clk     (clk),
      .rst_i   (rst),
      .start_i (accept && req_mul),
      .step_i  (state_q == ST_BUSY),
      .a_i     (a),
      .b_i     (b),
      .prod_o  (mul_prod),
      .done_o  (mul_done)
   );
`endif

   // Single-cycle datapath; multiply yields 0 here and is either replaced or flagged illegal.
   always_comb begin
      alu_y = '0;
      alu_c = 1'b0;
      if (ctrl == CLS_ARITH) begin
         case (S)
            SEL_ADD: {alu_c, alu_y} = {1'b0, a} + {1'b0, b};
            SEL_SUB: {alu_c, alu_y} = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
            SEL_INC: {alu_c, alu_y} = {1'b0, a} + (WIDTH + 1)'(1);
            default: begin
               alu_y = '0;
               alu_c = 1'b0;
            end
         endcase
      end else begin
         case (S)
            SEL_AND: alu_y = a & b;
            SEL_OR:  alu_y = a | b;
            SEL_XOR: alu_y = a ^ b;
            default: alu_y = ~a;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
`ifdef ALU_PIPE_MUL_EN
               state_d = req_mul ? ST_BUSY : ST_DONE;
`else
               state_d = ST_DONE;
`endif
            end
         end
         ST_BUSY: begin
`ifdef ALU_PIPE_MUL_EN
            if (mul_done) state_d = ST_DONE;
`else
            state_d = ST_IDLE;
`endif
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
   end

   // Result registers only load when entering DONE, so they hold steady for the consumer.
   always_comb begin
      y_d       = y_q;
      yhi_d     = yhi_q;
      carry_d   = carry_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
`ifdef ALU_PIPE_MUL_EN
      if (accept && !req_mul) begin
         y_d       = alu_y;
         yhi_d     = '0;
         carry_d   = alu_c;
         zero_d    = (alu_y == '0);
         illegal_d = 1'b0;
      end else if (state_q == ST_BUSY && mul_done) begin
         y_d       = mul_prod[WIDTH-1:0];
         yhi_d     = mul_prod[2*WIDTH-1:WIDTH];
         carry_d   = 1'b0;
         zero_d    = (mul_prod == '0);
         illegal_d = 1'b0;
      end
`else
      if (accept) begin
         y_d       = alu_y;
         yhi_d     = '0;
         carry_d   = alu_c;
         zero_d    = (alu_y == '0);
         illegal_d = req_mul;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_q       <= '0;
         yhi_q     <= '0;
         carry_q   <= 1'b0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         y_q       <= y_d;
         yhi_q     <= yhi_d;
         carry_q   <= carry_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
      end
   end

   assign Y       = y_q;
   assign Y_hi    = yhi_q;
   assign carry   = carry_q;
   assign zero    = zero_q;
   assign illegal = illegal_q;

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the operand and result width (legal values 4 to 32).
REQ-002 The block SHALL have parameter MUL_CYCLES_W, default 6, the width of the multiplier iteration counter (2^MUL_CYCLES_W >= WIDTH).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset; reset is synchronous and active-high.
REQ-005 The block SHALL have port a, input, WIDTH bits, operand A.
REQ-006 The block SHALL have port b, input, WIDTH bits, operand B.
REQ-007 The block SHALL have port ctrl, input, 1 bit, operation class: 1 = arithmetic, 0 = logic.
REQ-008 The block SHALL have port S, input, 2 bits, operation select within the class.
REQ-009 The block SHALL have port in_valid, input, 1 bit, request valid.
REQ-010 The block SHALL have port in_ready, output, 1 bit, block can accept a request.
REQ-011 The block SHALL have port Y, output, WIDTH bits, result low word.
REQ-012 The block SHALL have port Y_hi, output, WIDTH bits, result high word (product high half, else 0).
REQ-013 The block SHALL have port carry, output, 1 bit, carry-out (add/inc) or no-borrow (sub), else 0.
REQ-014 The block SHALL have port zero, output, 1 bit, set when {Y_hi,Y} == 0.
REQ-015 The block SHALL have port illegal, output, 1 bit, set when the operation is not supported in this build.
REQ-016 The block SHALL have port out_valid, output, 1 bit, result valid.
REQ-017 The block SHALL have port out_ready, input, 1 bit, consumer accepts the result.

Function
REQ-018 The block SHALL decode ctrl=1 as S=00 add, S=01 sub (a-b), S=10 multiply (unsigned, 2*WIDTH product), S=11 increment a.
REQ-019 The block SHALL decode ctrl=0 as S=00 AND, S=01 OR, S=10 XOR, S=11 NOT a.
REQ-020 The block SHALL implement a state machine with states IDLE, BUSY and DONE.
REQ-021 The block SHALL drive in_ready high only in IDLE; a request is accepted on a clock edge where in_valid and in_ready are both high, and the operands and opcode are registered at that edge.
REQ-022 The block SHALL complete a non-multiply operation by moving IDLE to DONE, with out_valid high in the cycle after acceptance (1-cycle latency).
REQ-023 The block SHALL handle a multiply by moving IDLE to BUSY and iterating shift-add for exactly WIDTH cycles, then moving to DONE; out_valid is high WIDTH+1 cycles after acceptance.
REQ-024 The block SHALL hold Y, Y_hi, carry, zero and illegal stable while in DONE and out_valid is high, until out_valid and out_ready are both high at a clock edge; DONE then moves to IDLE.
REQ-025 The block SHALL keep in_ready low in DONE, so no request is accepted in the same cycle a result is retired.
REQ-026 The block SHALL compute add, sub and increment modulo 2^WIDTH, so wrap-around is reported through carry (e.g. inc of all-ones gives Y=0, carry=1, zero=1).
REQ-027 The block SHALL ignore in_valid and a/b/ctrl/S changes while in BUSY or DONE.

Reset
REQ-028 The block SHALL, on a clock edge with rst high, enter IDLE and clear Y, Y_hi, carry, zero, illegal, out_valid and the iteration counter, with in_ready high after that edge.
REQ-029 The block SHALL abort an operation in progress when rst is asserted in BUSY or DONE, produce no out_valid for it, and give rst priority over every handshake.

Configuration
REQ-030 The block SHALL, with macro ALU_PIPE_MUL_EN defined, implement multiply per REQ-023.
REQ-031 The block SHALL, without ALU_PIPE_MUL_EN, complete multiply in 1 cycle with Y=0, Y_hi=0, zero=1 and illegal=1, omit the multiplier logic, and leave every other operation unchanged.

Structure
REQ-032 The block SHALL take its opcode constants (class and select encodings) and state encodings from shared package alu_pkg.
REQ-033 The block SHALL place the shift-add multiplier datapath (accumulator, multiplicand shift, iteration counter, done pulse) in sub-module alu_mul_seq, instantiated only under ALU_PIPE_MUL_EN.

Verification
REQ-034 Verification SHALL cover: WIDTH=8, a=0xBF, b=0x33, ctrl=1, S=00 -> one cycle later out_valid=1, Y=0xF2, carry=0, zero=0.
REQ-035 Verification SHALL cover: same operands, ctrl=1, S=01 -> Y=0x8C, carry=1; then ctrl=0, S=00 -> Y=0x33; then ctrl=0, S=10 -> Y=0x8C.
REQ-036 Verification SHALL cover: MUL_EN defined, a=0xBF, b=0x33, ctrl=1, S=10 -> out_valid 9 cycles after acceptance, Y_hi=0x26, Y=0x0D, in_ready low throughout; without MUL_EN -> illegal=1, Y=0 after 1 cycle.
REQ-037 Verification SHALL cover: a=0xFF, ctrl=1, S=11 -> Y=0x00, carry=1, zero=1.
REQ-038 Verification SHALL cover: out_ready held low for 5 cycles in DONE -> outputs stable and in_ready low; out_ready high -> next cycle IDLE, in_ready=1.
REQ-039 Verification SHALL cover: rst asserted in the 4th BUSY cycle of a multiply -> next cycle all outputs 0, in_ready=1, and no out_valid for the aborted request.
